// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: FSM states,
// opcodes, ALU operation classes, ALU controls, immediate types and
// datapath mux selects.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECUTEI = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALUC_ADD = 3'b000;
    localparam logic [2:0] ALUC_SUB = 3'b001;
    localparam logic [2:0] ALUC_AND = 3'b010;
    localparam logic [2:0] ALUC_OR  = 3'b011;
    localparam logic [2:0] ALUC_SLT = 3'b101;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// Maps the FSM's ALU operation class plus instruction fields onto the
// shared ALU's control code. Unsupported funct3 values fall back to add.
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] alu_control
);

    // ALU control decode
    always_comb begin
        alu_control = ALUC_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALUC_ADD;
            ALUOP_SUB: alu_control = ALUC_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  alu_control = (op5 & funct7b5) ? ALUC_SUB : ALUC_ADD;
                    3'b010:  alu_control = ALUC_SLT;
                    3'b110:  alu_control = ALUC_OR;
                    3'b111:  alu_control = ALUC_AND;
                    default: alu_control = ALUC_ADD;
                endcase
            end
            default: alu_control = ALUC_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM for the multi-cycle RV32I core: sequences fetch,
// decode, address, memory, execute and writeback over a shared ALU and a
// unified memory, stalling on mem_ready.
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       retire,
    output logic       illegal,
    output logic [3:0] state_dbg
);

    state_t     state;
    logic       pc_update;
    logic       branch;
    logic       ir_write;
    logic       reg_write;
    logic       mem_write;
    logic       retire_c;
    logic       illegal_c;
    logic [1:0] alu_op;

    // State sequencing; undefined encodings fall back to FETCH
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_FETCH;
        end else begin
            case (state)
                S_FETCH:    if (mem_ready) state <= S_DECODE;
                S_DECODE: begin
                    case (op)
                        OP_LOAD, OP_STORE: state <= S_MEMADR;
                        OP_RTYPE:          state <= S_EXECUTER;
                        OP_ITYPE:          state <= S_EXECUTEI;
                        OP_JAL:            state <= S_JAL;
                        OP_BEQ:            state <= S_BEQ;
                        default:           state <= S_TRAP;
                    endcase
                end
                S_MEMADR:   state <= op[5] ? S_MEMWRITE : S_MEMREAD;
                S_MEMREAD:  if (mem_ready) state <= S_MEMWB;
                S_MEMWB:    state <= S_FETCH;
                S_MEMWRITE: if (mem_ready) state <= S_FETCH;
                S_EXECUTER: state <= S_ALUWB;
                S_EXECUTEI: state <= S_ALUWB;
                S_ALUWB:    state <= S_FETCH;
                S_JAL:      state <= S_ALUWB;
                S_BEQ:      state <= S_FETCH;
                S_TRAP:     if (!HALT_ON_ILLEGAL) state <= S_FETCH;
                default:    state <= S_FETCH;
            endcase
        end
    end

    // Per-state datapath controls; anything not set for a state stays 0
    always_comb begin
        pc_update = 1'b0;
        branch    = 1'b0;
        ir_write  = 1'b0;
        reg_write = 1'b0;
        mem_write = 1'b0;
        retire_c  = 1'b0;
        illegal_c = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = RES_ALUOUT;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_RS2;
        alu_op    = ALUOP_ADD;
        case (state)
            S_FETCH: begin
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                ir_write  = mem_ready;
                pc_update = mem_ready;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                reg_write = 1'b1;
                retire_c  = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc    = 1'b1;
                mem_write = 1'b1;
                retire_c  = mem_ready;
            end
            S_EXECUTER: begin
                ALUSrcA = SRCA_RS1;
                alu_op  = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                alu_op  = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                retire_c  = 1'b1;
            end
            S_JAL: begin
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_FOUR;
                pc_update = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA  = SRCA_RS1;
                alu_op   = ALUOP_SUB;
                branch   = 1'b1;
                retire_c = 1'b1;
            end
            S_TRAP: begin
                illegal_c = 1'b1;
            end
            default: ;
        endcase
    end

    // Immediate format follows the opcode directly, independent of state
    always_comb begin
        case (op)
            OP_LOAD, OP_ITYPE: ImmSrc = IMM_I;
            OP_STORE:          ImmSrc = IMM_S;
            OP_BEQ:            ImmSrc = IMM_B;
            OP_JAL:            ImmSrc = IMM_J;
            default:           ImmSrc = IMM_I;
        endcase
    end

    // Strobes are gated by reset so they drop the moment reset asserts
    assign PCWrite   = reset & (pc_update | (branch & zero));
    assign IRWrite   = reset & ir_write;
    assign RegWrite  = reset & reg_write;
    assign MemWrite  = reset & mem_write;
    assign retire    = reset & retire_c;
    assign illegal   = reset & illegal_c;
    assign state_dbg = state;

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .op5         (op[5]),
        .funct7b5    (funct7b5),
        .alu_control (ALUControl)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: one halting and one
// non-halting instance share stimulus; inputs change 1 time unit after
// the rising edge and outputs are checked 2 units later.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;

    logic       PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, retire, illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] state_dbg;

    logic       nh_PCWrite, nh_AdrSrc, nh_IRWrite, nh_MemWrite, nh_RegWrite, nh_retire, nh_illegal;
    logic [1:0] nh_ResultSrc, nh_ALUSrcA, nh_ALUSrcB, nh_ImmSrc;
    logic [2:0] nh_ALUControl;
    logic [3:0] nh_state_dbg;

    logic [5:0] strobes;
    logic [5:0] nh_strobes;
    assign strobes    = {PCWrite, IRWrite, RegWrite, MemWrite, retire, illegal};
    assign nh_strobes = {nh_PCWrite, nh_IRWrite, nh_RegWrite, nh_MemWrite, nh_retire, nh_illegal};

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    multicycle_controller #(.HALT_ON_ILLEGAL(1'b1)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite), .MemWrite(MemWrite),
        .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ImmSrc(ImmSrc), .ALUControl(ALUControl), .retire(retire), .illegal(illegal),
        .state_dbg(state_dbg)
    );

    multicycle_controller #(.HALT_ON_ILLEGAL(1'b0)) dut_nh (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(mem_ready),
        .PCWrite(nh_PCWrite), .AdrSrc(nh_AdrSrc), .IRWrite(nh_IRWrite), .MemWrite(nh_MemWrite),
        .RegWrite(nh_RegWrite), .ResultSrc(nh_ResultSrc), .ALUSrcA(nh_ALUSrcA), .ALUSrcB(nh_ALUSrcB),
        .ImmSrc(nh_ImmSrc), .ALUControl(nh_ALUControl), .retire(nh_retire), .illegal(nh_illegal),
        .state_dbg(nh_state_dbg)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; mem_ready = 1'b1; op = 7'b0000011; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b0;
        tick();
        #2;
        total_cnt++;
        if (state_dbg !== 4'd0) $display("FAIL reset_state: got %0d want 0", state_dbg);
        else pass_cnt++;
        total_cnt++;
        if (strobes !== 6'b000000) $display("FAIL reset_strobes: got %b want 000000", strobes);
        else pass_cnt++;
        total_cnt++;
        if (nh_state_dbg !== 4'd0) $display("FAIL reset_state_nh: got %0d want 0", nh_state_dbg);
        else pass_cnt++;
        tick();
        reset = 1'b1;
    endtask

    task automatic test_lw();
        logic [3:0] exp_st [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
        logic [5:0] exp_sb [5] = '{6'b110000, 6'b000000, 6'b000000, 6'b000000, 6'b001010};
        op = 7'b0000011; mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #2;
            total_cnt++;
            if (state_dbg !== exp_st[i]) $display("FAIL lw_state c%0d: got %0d want %0d", i, state_dbg, exp_st[i]);
            else pass_cnt++;
            total_cnt++;
            if (strobes !== exp_sb[i]) $display("FAIL lw_strobes c%0d: got %b want %b", i, strobes, exp_sb[i]);
            else pass_cnt++;
            if (i == 3) begin
                total_cnt++;
                if (AdrSrc !== 1'b1) $display("FAIL lw_adrsrc: got %b want 1", AdrSrc);
                else pass_cnt++;
            end
            if (i == 4) begin
                total_cnt++;
                if (ResultSrc !== 2'b01) $display("FAIL lw_resultsrc: got %b want 01", ResultSrc);
                else pass_cnt++;
            end
            tick();
        end
        #2;
        total_cnt++;
        if (state_dbg !== 4'd0) $display("FAIL lw_end_state: got %0d want 0", state_dbg);
        else pass_cnt++;
    endtask

    task automatic test_sw_stall();
        logic       mr     [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [3:0] exp_st [6] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd5};
        logic [5:0] exp_sb [6] = '{6'b110000, 6'b000000, 6'b000000, 6'b000100, 6'b000100, 6'b000110};
        op = 7'b0100011;
        for (int i = 0; i < 6; i++) begin
            mem_ready = mr[i];
            #2;
            total_cnt++;
            if (state_dbg !== exp_st[i]) $display("FAIL sw_state c%0d: got %0d want %0d", i, state_dbg, exp_st[i]);
            else pass_cnt++;
            total_cnt++;
            if (strobes !== exp_sb[i]) $display("FAIL sw_strobes c%0d: got %b want %b", i, strobes, exp_sb[i]);
            else pass_cnt++;
            if (i == 2) begin
                total_cnt++;
                if (ImmSrc !== 2'b01) $display("FAIL sw_immsrc: got %b want 01", ImmSrc);
                else pass_cnt++;
            end
            tick();
        end
        mem_ready = 1'b1;
        #2;
        total_cnt++;
        if (state_dbg !== 4'd0) $display("FAIL sw_end_state: got %0d want 0", state_dbg);
        else pass_cnt++;
    endtask

    // Fields: op[17:11] funct3[10:8] funct7b5[7] ALUControl[6:4] execute state[3:0]
    localparam logic [17:0] ALU_VEC [7] = '{
        {7'b0110011, 3'b000, 1'b1, 3'b001, 4'd6},
        {7'b0110011, 3'b000, 1'b0, 3'b000, 4'd6},
        {7'b0110011, 3'b111, 1'b0, 3'b010, 4'd6},
        {7'b0110011, 3'b010, 1'b0, 3'b101, 4'd6},
        {7'b0110011, 3'b110, 1'b0, 3'b011, 4'd6},
        {7'b0010011, 3'b000, 1'b1, 3'b000, 4'd8},
        {7'b0110011, 3'b001, 1'b0, 3'b000, 4'd6}
    };

    task automatic test_alu();
        logic [17:0] v;
        logic [1:0]  exp_b;
        mem_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            v = ALU_VEC[k];
            op = v[17:11]; funct3 = v[10:8]; funct7b5 = v[7];
            exp_b = (v[3:0] == 4'd6) ? 2'b00 : 2'b01;
            tick();
            #2;
            total_cnt++;
            if (ALUControl !== 3'b000) $display("FAIL alu_decode_add v%0d: got %b want 000", k, ALUControl);
            else pass_cnt++;
            tick();
            #2;
            total_cnt++;
            if (state_dbg !== v[3:0]) $display("FAIL alu_exec_state v%0d: got %0d want %0d", k, state_dbg, v[3:0]);
            else pass_cnt++;
            total_cnt++;
            if (ALUControl !== v[6:4]) $display("FAIL alu_control v%0d: got %b want %b", k, ALUControl, v[6:4]);
            else pass_cnt++;
            total_cnt++;
            if ({ALUSrcA, ALUSrcB} !== {2'b10, exp_b}) $display("FAIL alu_srcs v%0d: got %b want %b", k, {ALUSrcA, ALUSrcB}, {2'b10, exp_b});
            else pass_cnt++;
            tick();
            #2;
            total_cnt++;
            if ({state_dbg, strobes} !== {4'd7, 6'b001010}) $display("FAIL alu_wb v%0d: got %h want %h", k, {state_dbg, strobes}, {4'd7, 6'b001010});
            else pass_cnt++;
            tick();
            #2;
            total_cnt++;
            if (state_dbg !== 4'd0) $display("FAIL alu_end_state v%0d: got %0d want 0", k, state_dbg);
            else pass_cnt++;
        end
        funct3 = 3'b000; funct7b5 = 1'b0;
    endtask

    task automatic test_beq();
        logic z;
        op = 7'b1100011; mem_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            z = (k == 0);
            zero = z;
            tick();
            #2;
            total_cnt++;
            if ({state_dbg, strobes} !== {4'd1, 6'b000000}) $display("FAIL beq_decode z%0b: got %h want %h", z, {state_dbg, strobes}, {4'd1, 6'b000000});
            else pass_cnt++;
            tick();
            #2;
            total_cnt++;
            if ({state_dbg, strobes} !== {4'd10, z, 5'b00010}) $display("FAIL beq_exec z%0b: got %h want %h", z, {state_dbg, strobes}, {4'd10, z, 5'b00010});
            else pass_cnt++;
            total_cnt++;
            if ({ALUControl, ImmSrc} !== {3'b001, 2'b10}) $display("FAIL beq_alu_imm z%0b: got %b want 00110", z, {ALUControl, ImmSrc});
            else pass_cnt++;
            tick();
            #2;
            total_cnt++;
            if (state_dbg !== 4'd0) $display("FAIL beq_end_state z%0b: got %0d want 0", z, state_dbg);
            else pass_cnt++;
        end
        zero = 1'b0;
    endtask

    task automatic test_jal();
        logic [3:0] exp_st [4] = '{4'd0, 4'd1, 4'd9, 4'd7};
        logic [5:0] exp_sb [4] = '{6'b110000, 6'b000000, 6'b100000, 6'b001010};
        op = 7'b1101111; mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #2;
            total_cnt++;
            if ({state_dbg, strobes} !== {exp_st[i], exp_sb[i]}) $display("FAIL jal c%0d: got %h want %h", i, {state_dbg, strobes}, {exp_st[i], exp_sb[i]});
            else pass_cnt++;
            if (i == 1) begin
                total_cnt++;
                if (ImmSrc !== 2'b11) $display("FAIL jal_immsrc: got %b want 11", ImmSrc);
                else pass_cnt++;
            end
            tick();
        end
        #2;
        total_cnt++;
        if (state_dbg !== 4'd0) $display("FAIL jal_end_state: got %0d want 0", state_dbg);
        else pass_cnt++;
    endtask

    task automatic test_trap();
        int bad;
        op = 7'b1110011; mem_ready = 1'b1;
        #2;
        total_cnt++;
        if (ImmSrc !== 2'b00) $display("FAIL trap_immsrc: got %b want 00", ImmSrc);
        else pass_cnt++;
        tick();
        tick();
        #2;
        total_cnt++;
        if ({nh_state_dbg, nh_strobes} !== {4'd11, 6'b000001}) $display("FAIL trap_nh_enter: got %h want %h", {nh_state_dbg, nh_strobes}, {4'd11, 6'b000001});
        else pass_cnt++;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 1) begin
                total_cnt++;
                if ({nh_state_dbg, nh_strobes} !== {4'd0, 6'b110000}) $display("FAIL trap_nh_exit: got %h want %h", {nh_state_dbg, nh_strobes}, {4'd0, 6'b110000});
                else pass_cnt++;
            end
            if ({state_dbg, strobes} !== {4'd11, 6'b000001}) begin
                if (bad == 0) $display("FAIL trap_hold c%0d: got %h want %h", i, {state_dbg, strobes}, {4'd11, 6'b000001});
                bad++;
            end
            tick();
            #2;
        end
        total_cnt++;
        if (bad != 0) $display("FAIL trap_hold_total: got %0d bad cycles want 0", bad);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_write();
        reset = 1'b0;
        #2;
        total_cnt++;
        if ({state_dbg, nh_state_dbg} !== 8'h00) $display("FAIL trap_reset_state: got %h want 00", {state_dbg, nh_state_dbg});
        else pass_cnt++;
        tick();
        reset = 1'b1; op = 7'b0100011; mem_ready = 1'b1;
        tick();
        tick();
        tick();
        mem_ready = 1'b0;
        #2;
        total_cnt++;
        if ({state_dbg, strobes} !== {4'd5, 6'b000100}) $display("FAIL rst_pre_write: got %h want %h", {state_dbg, strobes}, {4'd5, 6'b000100});
        else pass_cnt++;
        reset = 1'b0;
        #1;
        total_cnt++;
        if ({state_dbg, strobes} !== {4'd0, 6'b000000}) $display("FAIL rst_mid_write: got %h want %h", {state_dbg, strobes}, {4'd0, 6'b000000});
        else pass_cnt++;
        tick();
        reset = 1'b1; mem_ready = 1'b0;
        #2;
        total_cnt++;
        if ({state_dbg, strobes} !== {4'd0, 6'b000000}) $display("FAIL rst_fetch_stall0: got %h want %h", {state_dbg, strobes}, {4'd0, 6'b000000});
        else pass_cnt++;
        tick();
        #2;
        total_cnt++;
        if ({state_dbg, strobes} !== {4'd0, 6'b000000}) $display("FAIL rst_fetch_stall1: got %h want %h", {state_dbg, strobes}, {4'd0, 6'b000000});
        else pass_cnt++;
        tick();
        mem_ready = 1'b1;
        #2;
        total_cnt++;
        if ({state_dbg, strobes} !== {4'd0, 6'b110000}) $display("FAIL rst_fetch_ready: got %h want %h", {state_dbg, strobes}, {4'd0, 6'b110000});
        else pass_cnt++;
        tick();
        #2;
        total_cnt++;
        if (state_dbg !== 4'd1) $display("FAIL rst_decode: got %0d want 1", state_dbg);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw_stall();
        test_alu();
        test_beq();
        test_jal();
        test_trap();
        test_reset_mid_write();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Main control FSM for the multi-cycle RV32I core variant, which shares one ALU and one unified instruction/data memory across cycles.
- Each cycle it drives every datapath enable and mux select: PC, IR, register file, memory address mux, ALU operand muxes and result mux.
- Memory accesses stall on a mem_ready handshake.
- Supports lw, sw, R-type ALU, I-type ALU, beq and jal; any other opcode traps.

Parameters:
- HALT_ON_ILLEGAL, 1: 1 = TRAP is terminal until reset; 0 = TRAP returns to FETCH after one cycle.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- op  in  7  instr[6:0]
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory has completed the current read or write this cycle
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut
- IRWrite  out  1  instruction register enable
- MemWrite  out  1  memory write strobe
- RegWrite  out  1  register file write enable
- ResultSrc  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA  out  2  operand A select: 00 = PC, 01 = OldPC, 10 = rs1
- ALUSrcB  out  2  operand B select: 00 = rs2, 01 = ImmExt, 10 = constant 4
- ImmSrc  out  2  immediate type: 00 = I, 01 = S, 10 = B, 11 = J
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- retire  out  1  one-cycle pulse on the final cycle of each completed instruction
- illegal  out  1  high while in TRAP
- state_dbg  out  4  current state encoding

Behaviour:
- Reset (reset=0, async): state := FETCH. PCWrite, IRWrite, RegWrite, MemWrite, retire and illegal are forced 0 while reset is low.
- Output model:
  - Moore outputs come from state.
  - PCWrite = PCUpdate | (Branch & zero).
  - Any output not listed for a state is 0.
- FETCH (0): AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite = PCUpdate = mem_ready.
  - Stays in FETCH while !mem_ready; goes to DECODE when mem_ready.
- DECODE (1): ALUSrcA=01, ALUSrcB=01, ALUOp=00 (computes the branch target). Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECUTER
  - 0010011 -> EXECUTEI
  - 1101111 -> JAL
  - 1100011 -> BEQ
  - anything else -> TRAP
- MEMADR (2): ALUSrcA=10, ALUSrcB=01, ALUOp=00. Goes to MEMREAD if op[5]=0, else MEMWRITE.
- MEMREAD (3): AdrSrc=1, ResultSrc=00. Waits for mem_ready, then MEMWB.
- MEMWB (4): ResultSrc=01, RegWrite=1, retire=1. Then FETCH.
- MEMWRITE (5): AdrSrc=1, ResultSrc=00, MemWrite=1.
  - MemWrite is held for every cycle until mem_ready.
  - retire=1 on the mem_ready cycle, then FETCH.
- EXECUTER (6): ALUSrcA=10, ALUSrcB=00, ALUOp=10. Then ALUWB.
- EXECUTEI (8): ALUSrcA=10, ALUSrcB=01, ALUOp=10. Then ALUWB.
- ALUWB (7): ResultSrc=00, RegWrite=1, retire=1. Then FETCH.
- JAL (9): ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. Then ALUWB.
- BEQ (10): ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1, retire=1. Then FETCH.
- TRAP (11): illegal=1, all enables 0.
  - HALT_ON_ILLEGAL=1: stays in TRAP until reset.
  - HALT_ON_ILLEGAL=0: goes to FETCH after one cycle, with no retire pulse.
  - Encodings 12-15 are unreachable and must recover to FETCH.
- ImmSrc is combinational from op: lw and I-ALU -> 00, sw -> 01, beq -> 10, jal -> 11, other -> 00.
- ALU decode:
  - ALUOp 00 -> add; ALUOp 01 -> sub.
  - ALUOp 10, funct3=000: sub if op[5] & funct7b5, else add.
  - ALUOp 10, funct3 010 -> slt, 110 -> or, 111 -> and.
  - Any other funct3 -> add (not trapped).
- Latency in cycles with zero-wait memory:
  - lw 5; sw 4; R-type and I-type 4; jal 4; beq 3.
  - Each mem_ready=0 cycle adds one cycle in FETCH, MEMREAD or MEMWRITE.
- Reset asserted mid-instruction (including during a held MemWrite) drops all strobes immediately. After release, execution restarts at FETCH.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - state encodings (4-bit);
  - opcode constants;
  - ALUOp, ALUControl and ImmSrc codes;
  - ResultSrc, ALUSrcA and ALUSrcB select codes.
- One sub-module, alu_decoder: (ALUOp, funct3, op5, funct7b5) -> ALUControl, purely combinational.
- The FSM, output decode and ImmSrc decode stay in multicycle_controller.

Test Plan:
- lw (op=0000011), mem_ready high -> states 0,1,2,3,4,0. RegWrite=1 only in state 4; retire pulses once; total 5 cycles.
- sw with mem_ready low for 2 cycles in MEMWRITE -> MemWrite=1 for 3 consecutive cycles. retire and the exit to FETCH occur on the mem_ready cycle.
- R-type sub (op=0110011, funct3=000, funct7b5=1) -> ALUControl=001 in EXECUTER. funct7b5=0 gives 000; funct3=111 gives 010; funct3=010 gives 101.
- beq with zero=1 -> PCWrite=1 in BEQ, ALUControl=001, ImmSrc=10. With zero=0 -> PCWrite=0; both cases take 3 cycles and return to FETCH.
- op=1110011 -> TRAP, illegal=1.
  - HALT_ON_ILLEGAL=1: holds in TRAP for 20 cycles, no enables asserted.
  - HALT_ON_ILLEGAL=0: back in FETCH after 1 cycle.
- Reset pulled low asynchronously mid-MEMWRITE -> MemWrite drops in the same cycle and state_dbg=0. After release, FETCH asserts IRWrite only when mem_ready=1.
